// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundles the control strobes between the hardwired sequencer and DataPath.
//
//   Signal summary:
//     IR_op[4:0]   opcode field IR[31:27]                  (datapath -> sequencer)
//     CON_FF       branch condition flip-flop output       (datapath -> sequencer)
//     Bus sources:    PCout, Zlowout, Zhighout, HIout, LOout,
//                     MDRout, InPortout, Cout, BAout, Rout
//     Register loads: MARin, PCin, MDRin, IRin, Yin, HIin, LOin,
//                     OutPortin, CONin, Rin, Zin_high, Zin_low
//     Register-select field enables: Gra, Grb, Grc
//     PC increment and memory strobes: IncPC, Read, Write
//     operation[4:0]  ALU opcode
//     Run             high while executing, low after halt
//
//   Modports:
//     master  the sequencer (control_unit): drives the strobes
//     slave   the datapath: drives IR_op and CON_FF
interface control_unit_if;
    logic [4:0] IR_op;
    logic       CON_FF;

    logic       PCout;
    logic       Zlowout;
    logic       Zhighout;
    logic       HIout;
    logic       LOout;
    logic       MDRout;
    logic       InPortout;
    logic       Cout;
    logic       BAout;
    logic       Rout;

    logic       MARin;
    logic       PCin;
    logic       MDRin;
    logic       IRin;
    logic       Yin;
    logic       HIin;
    logic       LOin;
    logic       OutPortin;
    logic       CONin;
    logic       Rin;
    logic       Zin_high;
    logic       Zin_low;

    logic       Gra;
    logic       Grb;
    logic       Grc;

    logic       IncPC;
    logic       Read;
    logic       Write;

    logic [4:0] operation;
    logic       Run;

    modport master (
        input  IR_op, CON_FF,
        output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout, BAout, Rout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin,
        output Zin_high, Zin_low,
        output Gra, Grb, Grc,
        output IncPC, Read, Write,
        output operation, Run
    );

    modport slave (
        output IR_op, CON_FF,
        input  PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout, BAout, Rout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin,
        input  Zin_high, Zin_low,
        input  Gra, Grb, Grc,
        input  IncPC, Read, Write,
        input  operation, Run
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
//   Hardwired Moore control sequencer for the 32-bit bus datapath. Steps one
//   state per rising Clock edge through fetch (T0-T2), decode (T3) and
//   execute (T4-T7), driving every bus-source, register-load, ALU-operation
//   and memory strobe of the datapath.
//
//   Ports:
//     Clock      sole clock, rising edge
//     clear      asynchronous active-low reset
//     bus        control_unit_if.master: IR_op/CON_FF in, all strobes out
//     state_dbg  current FSM state encoding (observation only)
//
//   All strobes are decoded combinationally from the state register and
//   IR_op, so an asynchronous clear drops every strobe within the same cycle.
module control_unit (
    input  logic                  Clock,
    input  logic                  clear,
    control_unit_if.master        bus,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_t;

    // Instruction groups that share a strobe sequence.
    typedef enum logic [3:0] {
        C_NOP,
        C_LDW,
        C_LDWI,
        C_STW,
        C_ALU_REG,
        C_ALU_IMM,
        C_UNARY,
        C_MULDIV,
        C_MFHI,
        C_MFLO,
        C_IN,
        C_OUT,
        C_JR,
        C_BRANCH,
        C_HALT
    } op_class_t;

    localparam logic [4:0] OP_LDW    = 5'b00000;
    localparam logic [4:0] OP_LDWI   = 5'b00001;
    localparam logic [4:0] OP_STW    = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_SHR    = 5'b00101;
    localparam logic [4:0] OP_SHL    = 5'b00110;
    localparam logic [4:0] OP_ROR    = 5'b00111;
    localparam logic [4:0] OP_ROL    = 5'b01000;
    localparam logic [4:0] OP_AND    = 5'b01001;
    localparam logic [4:0] OP_OR     = 5'b01010;
    localparam logic [4:0] OP_ADDI   = 5'b01011;
    localparam logic [4:0] OP_ANDI   = 5'b01100;
    localparam logic [4:0] OP_ORI    = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_NEG    = 5'b10000;
    localparam logic [4:0] OP_NOT    = 5'b10001;
    localparam logic [4:0] OP_BRANCH = 5'b10010;
    localparam logic [4:0] OP_JR     = 5'b10011;
    localparam logic [4:0] OP_IN     = 5'b10101;
    localparam logic [4:0] OP_OUT    = 5'b10110;
    localparam logic [4:0] OP_MFHI   = 5'b10111;
    localparam logic [4:0] OP_MFLO   = 5'b11000;
    localparam logic [4:0] OP_HALT   = 5'b11010;

    state_t    state;
    state_t    state_next;
    op_class_t op_class;

    // Local strobe copies; mapped onto the interface at the bottom.
    logic       pc_out, zlow_out, zhigh_out, hi_out, lo_out;
    logic       mdr_out, inport_out, c_out, ba_out, r_out;
    logic       mar_in, pc_in, mdr_in, ir_in, y_in;
    logic       hi_in, lo_in, outport_in, con_in, r_in;
    logic       z_in;
    logic       gra, grb, grc;
    logic       inc_pc, rd, wr;
    logic [4:0] alu_op;
    logic       run;

    // ------------------------------------------------------------------
    // Opcode classification. nop and every unassigned opcode fall into
    // C_NOP, which spends T3 idle and returns to fetch.
    // ------------------------------------------------------------------
    always_comb begin
        op_class = C_NOP;
        case (bus.IR_op)
            OP_LDW:    op_class = C_LDW;
            OP_LDWI:   op_class = C_LDWI;
            OP_STW:    op_class = C_STW;
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:
                       op_class = C_ALU_REG;
            OP_ADDI, OP_ANDI, OP_ORI:
                       op_class = C_ALU_IMM;
            OP_NEG, OP_NOT:
                       op_class = C_UNARY;
            OP_MUL, OP_DIV:
                       op_class = C_MULDIV;
            OP_MFHI:   op_class = C_MFHI;
            OP_MFLO:   op_class = C_MFLO;
            OP_IN:     op_class = C_IN;
            OP_OUT:    op_class = C_OUT;
            OP_JR:     op_class = C_JR;
            OP_BRANCH: op_class = C_BRANCH;
            OP_HALT:   op_class = C_HALT;
            default:   op_class = C_NOP;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= RST;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The length of each instruction is set by where
    // its class leaves the T3..T7 chain back to T0.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            RST: state_next = T0;
            T0:  state_next = T1;
            T1:  state_next = T2;
            T2:  state_next = T3;
            T3: begin
                case (op_class)
                    C_LDW, C_LDWI, C_STW, C_ALU_REG, C_ALU_IMM,
                    C_UNARY, C_MULDIV, C_BRANCH:
                        state_next = T4;
                    C_HALT:
                        state_next = HALT;
                    default:
                        state_next = T0;
                endcase
            end
            T4: begin
                case (op_class)
                    C_LDW, C_LDWI, C_STW, C_ALU_REG, C_ALU_IMM,
                    C_MULDIV, C_BRANCH:
                        state_next = T5;
                    default:
                        state_next = T0;
                endcase
            end
            T5: begin
                case (op_class)
                    C_LDW, C_STW, C_MULDIV, C_BRANCH:
                        state_next = T6;
                    default:
                        state_next = T0;
                endcase
            end
            T6: begin
                case (op_class)
                    C_LDW, C_STW: state_next = T7;
                    default:      state_next = T0;
                endcase
            end
            T7:      state_next = T0;
            HALT:    state_next = HALT;
            default: state_next = RST;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_out     = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        hi_out     = 1'b0;
        lo_out     = 1'b0;
        mdr_out    = 1'b0;
        inport_out = 1'b0;
        c_out      = 1'b0;
        ba_out     = 1'b0;
        r_out      = 1'b0;
        mar_in     = 1'b0;
        pc_in      = 1'b0;
        mdr_in     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        outport_in = 1'b0;
        con_in     = 1'b0;
        r_in       = 1'b0;
        z_in       = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        inc_pc     = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        alu_op     = OP_ADD;
        run        = 1'b1;

        case (state)
            RST: begin
                alu_op = 5'b00000;
            end
            T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                rd       = 1'b1;
                mdr_in   = 1'b1;
            end
            T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            T3: begin
                case (op_class)
                    C_LDW, C_LDWI, C_STW: begin
                        // Base register through BAout so R0 reads as zero.
                        grb    = 1'b1;
                        ba_out = 1'b1;
                        y_in   = 1'b1;
                    end
                    C_ALU_REG, C_ALU_IMM: begin
                        grb   = 1'b1;
                        r_out = 1'b1;
                        y_in  = 1'b1;
                    end
                    C_UNARY: begin
                        grb    = 1'b1;
                        r_out  = 1'b1;
                        z_in   = 1'b1;
                        alu_op = bus.IR_op;
                    end
                    C_MULDIV: begin
                        gra   = 1'b1;
                        r_out = 1'b1;
                        y_in  = 1'b1;
                    end
                    C_MFHI: begin
                        hi_out = 1'b1;
                        gra    = 1'b1;
                        r_in   = 1'b1;
                    end
                    C_MFLO: begin
                        lo_out = 1'b1;
                        gra    = 1'b1;
                        r_in   = 1'b1;
                    end
                    C_IN: begin
                        inport_out = 1'b1;
                        gra        = 1'b1;
                        r_in       = 1'b1;
                    end
                    C_OUT: begin
                        gra        = 1'b1;
                        r_out      = 1'b1;
                        outport_in = 1'b1;
                    end
                    C_JR: begin
                        gra   = 1'b1;
                        r_out = 1'b1;
                        pc_in = 1'b1;
                    end
                    C_BRANCH: begin
                        gra    = 1'b1;
                        r_out  = 1'b1;
                        con_in = 1'b1;
                    end
                    default: begin
                        // nop, halt and unassigned opcodes idle here.
                    end
                endcase
            end
            T4: begin
                case (op_class)
                    C_LDW, C_LDWI, C_STW: begin
                        c_out = 1'b1;
                        z_in  = 1'b1;
                    end
                    C_ALU_REG: begin
                        grc    = 1'b1;
                        r_out  = 1'b1;
                        z_in   = 1'b1;
                        alu_op = bus.IR_op;
                    end
                    C_ALU_IMM: begin
                        c_out  = 1'b1;
                        z_in   = 1'b1;
                        alu_op = bus.IR_op;
                    end
                    C_UNARY: begin
                        zlow_out = 1'b1;
                        gra      = 1'b1;
                        r_in     = 1'b1;
                    end
                    C_MULDIV: begin
                        grb    = 1'b1;
                        r_out  = 1'b1;
                        z_in   = 1'b1;
                        alu_op = bus.IR_op;
                    end
                    C_BRANCH: begin
                        pc_out = 1'b1;
                        y_in   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T5: begin
                case (op_class)
                    C_LDW, C_STW: begin
                        zlow_out = 1'b1;
                        mar_in   = 1'b1;
                    end
                    C_LDWI, C_ALU_REG, C_ALU_IMM: begin
                        zlow_out = 1'b1;
                        gra      = 1'b1;
                        r_in     = 1'b1;
                    end
                    C_MULDIV: begin
                        zlow_out = 1'b1;
                        lo_in    = 1'b1;
                    end
                    C_BRANCH: begin
                        c_out = 1'b1;
                        z_in  = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T6: begin
                case (op_class)
                    C_LDW: begin
                        rd     = 1'b1;
                        mdr_in = 1'b1;
                    end
                    C_STW: begin
                        // MDR loads from the bus (Read low) ready for the write.
                        gra    = 1'b1;
                        r_out  = 1'b1;
                        mdr_in = 1'b1;
                    end
                    C_MULDIV: begin
                        zhigh_out = 1'b1;
                        hi_in     = 1'b1;
                    end
                    C_BRANCH: begin
                        // CON_FF was loaded at the end of T3 and is stable here.
                        zlow_out = 1'b1;
                        pc_in    = bus.CON_FF;
                    end
                    default: begin
                    end
                endcase
            end
            T7: begin
                case (op_class)
                    C_LDW: begin
                        mdr_out = 1'b1;
                        gra     = 1'b1;
                        r_in    = 1'b1;
                    end
                    C_STW: begin
                        wr = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            HALT: begin
                alu_op = 5'b00000;
                run    = 1'b0;
            end
            default: begin
                alu_op = 5'b00000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Drive the interface
    // ------------------------------------------------------------------
    assign bus.PCout     = pc_out;
    assign bus.Zlowout   = zlow_out;
    assign bus.Zhighout  = zhigh_out;
    assign bus.HIout     = hi_out;
    assign bus.LOout     = lo_out;
    assign bus.MDRout    = mdr_out;
    assign bus.InPortout = inport_out;
    assign bus.Cout      = c_out;
    assign bus.BAout     = ba_out;
    assign bus.Rout      = r_out;

    assign bus.MARin     = mar_in;
    assign bus.PCin      = pc_in;
    assign bus.MDRin     = mdr_in;
    assign bus.IRin      = ir_in;
    assign bus.Yin       = y_in;
    assign bus.HIin      = hi_in;
    assign bus.LOin      = lo_in;
    assign bus.OutPortin = outport_in;
    assign bus.CONin     = con_in;
    assign bus.Rin       = r_in;
    assign bus.Zin_high  = z_in;
    assign bus.Zin_low   = z_in;

    assign bus.Gra       = gra;
    assign bus.Grb       = grb;
    assign bus.Grc       = grc;

    assign bus.IncPC     = inc_pc;
    assign bus.Read      = rd;
    assign bus.Write     = wr;

    assign bus.operation = alu_op;
    assign bus.Run       = run;

    assign state_dbg     = state;

endmodule
